// File: rtl/axi_lite_loop_regs_if.sv
// AXI4-Lite control-port bundle between the master agent and the loop register file.
// Carries the five AXI4-Lite channels; clock and reset travel as separate scalar ports.
// The slave modport is the responder view; the master modport is the driver view.
interface axi_lite_loop_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_loop_regs.sv
// AXI4-Lite slave holding NUM_REGS byte-writable control words for the stream loop datapath.
// Latency: BVALID/new value 1 cycle after the last AW/W handshake; RVALID 1 cycle after AR.
// Backpressure: one write and one read outstanding; BREADY/RREADY low stalls only its channel.
module axi_lite_loop_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  axi_lite_loop_regs_if.slave          s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write-side state: AW/W holding latches plus registered handshake outputs.
  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NBYTES-1:0]     w_strb_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [NUM_REGS-1:0]   pulse_q;

  // Read-side state.
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Next-state terms.
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [IDX_W-1:0]      cmt_idx;
  logic [DATA_WIDTH-1:0] cmt_data;
  logic [NBYTES-1:0]     cmt_strb;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Handshake decode and commit selection; a payload arriving this cycle bypasses its latch.
  always_comb begin
    aw_hs     = s_axi.S_AXI_AWVALID && awready_q;
    w_hs      = s_axi.S_AXI_WVALID && wready_q;
    ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
    commit    = (aw_held || aw_hs) && (w_held || w_hs);
    cmt_idx   = aw_hs ? s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
    cmt_data  = w_hs ? s_axi.S_AXI_WDATA : w_data_q;
    cmt_strb  = w_hs ? s_axi.S_AXI_WSTRB : w_strb_q;
    aw_held_n = (aw_held || aw_hs) && !commit;
    w_held_n  = (w_held || w_hs) && !commit;
    bvalid_n  = commit || (bvalid_q && !s_axi.S_AXI_BREADY);
    rvalid_n  = ar_hs || (rvalid_q && !s_axi.S_AXI_RREADY);
  end

  // Write channels: latch payloads, commit strobed bytes, raise BVALID and the update strobe.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      pulse_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      bvalid_q  <= bvalid_n;
      awready_q <= !aw_held_n && !bvalid_n;
      wready_q  <= !w_held_n && !bvalid_n;
      if (aw_hs) aw_idx_q <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      pulse_q <= commit ? (NUM_REGS'(1) << cmt_idx) : '0;
      if (commit) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (cmt_strb[b]) regs_q[cmt_idx][8*b +: 8] <= cmt_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel: sample the pre-write register value on AR, hold until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_n;
      arready_q <= !rvalid_n;
      if (ar_hs) rdata_q <= regs_q[s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2]];
    end
  end

  // Flatten the register array onto the datapath-facing bus.
  always_comb begin
    regs_out = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

  assign reg_wr_pulse        = pulse_q;
  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
endmodule

// File: tb/tb_axi_lite_loop_regs.sv
// Bench for axi_lite_loop_regs: directed AXI4-Lite traffic with a queue-based scoreboard.
// Stimulus tasks push expected B/R responses; a negedge monitor pops and compares on handshakes.
// Inline checks cover reset values, latency, strobes, backpressure, collision and mid-op reset.
module tb_axi_lite_loop_regs;
  logic         ACLK;
  logic         ARESET;
  logic [127:0] regs_out;
  logic [3:0]   reg_wr_pulse;

  axi_lite_loop_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bif();

  axi_lite_loop_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .s_axi        (bif),
    .regs_out     (regs_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_chk  = 0;
  int n_pass = 0;
  logic [1:0]  exp_b[$];
  logic [31:0] exp_r[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Scoreboard monitor: a response is consumed on the edge following a negedge with VALID && READY.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (bif.S_AXI_BVALID && bif.S_AXI_BREADY) begin
        if (exp_b.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected: actual=response required=none");
        end else chk("bresp", {126'd0, bif.S_AXI_BRESP}, {126'd0, exp_b.pop_front()});
      end
      if (bif.S_AXI_RVALID && bif.S_AXI_RREADY) begin
        if (exp_r.size() == 0) begin
          n_chk++;
          $display("FAIL r_unexpected: actual=%0h required=none", bif.S_AXI_RDATA);
        end else chk("rresp_rdata", {94'd0, bif.S_AXI_RRESP, bif.S_AXI_RDATA},
                     {94'd0, 2'b00, exp_r.pop_front()});
      end
    end
  end

  // Write with independent per-channel start delays (in cycles).
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_go, w_go;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    exp_b.push_back(2'b00);
    while (!(aw_done && w_done) && c < 100) begin
      if (!aw_done && c >= aw_dly) begin bif.S_AXI_AWADDR = addr; bif.S_AXI_AWVALID = 1'b1; end
      if (!w_done && c >= w_dly) begin
        bif.S_AXI_WDATA = data; bif.S_AXI_WSTRB = strb; bif.S_AXI_WVALID = 1'b1;
      end
      @(negedge ACLK);
      aw_go = bif.S_AXI_AWVALID && bif.S_AXI_AWREADY;
      w_go  = bif.S_AXI_WVALID && bif.S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) begin bif.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_go)  begin bif.S_AXI_WVALID = 1'b0; w_done = 1; end
      c++;
    end
    if (!(aw_done && w_done)) begin
      n_chk++;
      $display("FAIL write_timeout: actual=aw%0d_w%0d required=both", aw_done, w_done);
      bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    bit go;
    int c;
    go = 0; c = 0;
    exp_r.push_back(exp);
    bif.S_AXI_ARADDR = addr; bif.S_AXI_ARVALID = 1'b1;
    while (!go && c < 100) begin
      @(negedge ACLK);
      go = bif.S_AXI_ARREADY;
      @(posedge ACLK); #1;
      c++;
    end
    bif.S_AXI_ARVALID = 1'b0;
    if (!go) begin n_chk++; $display("FAIL read_timeout: actual=none required=handshake"); end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && c < 50) begin @(posedge ACLK); c++; end
    @(posedge ACLK); #1;
    chk("drain", 128'(exp_b.size() + exp_r.size()), 128'd0);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (!(bif.S_AXI_AWREADY && bif.S_AXI_WREADY && bif.S_AXI_ARREADY) && c < 50) begin
      @(negedge ACLK); c++;
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    ARESET = 1'b1;
    bif.S_AXI_AWADDR = '0; bif.S_AXI_AWPROT = '0; bif.S_AXI_AWVALID = 1'b0;
    bif.S_AXI_WDATA = '0; bif.S_AXI_WSTRB = '0; bif.S_AXI_WVALID = 1'b0;
    bif.S_AXI_BREADY = 1'b1;
    bif.S_AXI_ARADDR = '0; bif.S_AXI_ARPROT = '0; bif.S_AXI_ARVALID = 1'b0;
    bif.S_AXI_RREADY = 1'b1;

    // Reset values.
    #12;
    chk("rst_ready", {125'd0, bif.S_AXI_AWREADY, bif.S_AXI_WREADY, bif.S_AXI_ARREADY}, 128'd0);
    chk("rst_valid", {126'd0, bif.S_AXI_BVALID, bif.S_AXI_RVALID}, 128'd0);
    chk("rst_rdata", {96'd0, bif.S_AXI_RDATA}, 128'd0);
    chk("rst_regs", regs_out, 128'd0);
    chk("rst_pulse", {124'd0, reg_wr_pulse}, 128'd0);
    @(posedge ACLK); #1; ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("ready_after_rst", {125'd0, bif.S_AXI_AWREADY, bif.S_AXI_WREADY, bif.S_AXI_ARREADY}, 128'd7);

    // Sequential writes then readback.
    for (int i = 0; i < 4; i++) axi_write(4'(4*i), 32'(i+1), 4'hF, 0, 0);
    chk("regs_seq", regs_out, 128'h00000004_00000003_00000002_00000001);
    for (int i = 0; i < 4; i++) axi_read(4'(4*i), 32'(i+1));
    drain();

    // Byte strobes and single-cycle update strobe.
    axi_write(4'h4, 32'h11223344, 4'hF, 0, 0);
    axi_write(4'h4, 32'hAABBCCDD, 4'h5, 0, 0);
    chk("strobe_pulse", {124'd0, reg_wr_pulse}, 128'b0010);
    chk("strobe_bvalid", {127'd0, bif.S_AXI_BVALID}, 128'd1);
    chk("strobe_reg1", {96'd0, regs_out[63:32]}, {96'd0, 32'h11BB33DD});
    @(posedge ACLK); #1;
    chk("strobe_pulse_off", {124'd0, reg_wr_pulse}, 128'd0);
    axi_read(4'h4, 32'h11BB33DD);

    // Channel ordering: AW first, then W three cycles ahead of AW.
    axi_write(4'h8, 32'h0000BEEF, 4'hF, 0, 3);
    chk("aw_first_bvalid", {127'd0, bif.S_AXI_BVALID}, 128'd1);
    chk("aw_first_reg2", {96'd0, regs_out[95:64]}, {96'd0, 32'h0000BEEF});
    axi_write(4'h8, 32'h0000CAFE, 4'hF, 3, 0);
    chk("w_first_bvalid", {127'd0, bif.S_AXI_BVALID}, 128'd1);
    chk("w_first_reg2", {96'd0, regs_out[95:64]}, {96'd0, 32'h0000CAFE});
    drain();

    // B-channel backpressure: second write must not be accepted while BVALID waits.
    bif.S_AXI_BREADY = 1'b0;
    axi_write(4'hC, 32'h77, 4'hF, 0, 0);
    bif.S_AXI_AWADDR = 4'hC; bif.S_AXI_AWVALID = 1'b1;
    bif.S_AXI_WDATA = 32'h88; bif.S_AXI_WSTRB = 4'hF; bif.S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bp_b_state", {125'd0, bif.S_AXI_BVALID, bif.S_AXI_AWREADY, bif.S_AXI_WREADY}, 128'b100);
      @(posedge ACLK); #1;
    end
    chk("bp_b_reg3", {96'd0, regs_out[127:96]}, {96'd0, 32'h77});
    bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0; bif.S_AXI_BREADY = 1'b1;
    axi_write(4'hC, 32'h88, 4'hF, 0, 0);
    chk("bp_b_reg3_new", {96'd0, regs_out[127:96]}, {96'd0, 32'h88});
    drain();

    // R-channel backpressure: RDATA holds stable while RREADY is low.
    bif.S_AXI_RREADY = 1'b0;
    axi_read(4'h4, 32'h11BB33DD);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bp_r_state", {94'd0, bif.S_AXI_RVALID, bif.S_AXI_ARREADY, bif.S_AXI_RDATA},
          {94'd0, 2'b10, 32'h11BB33DD});
      @(posedge ACLK); #1;
    end
    bif.S_AXI_RREADY = 1'b1;
    drain();

    // Write commit and AR to the same word on the same edge: read sees the old value.
    wait_idle();
    exp_b.push_back(2'b00);
    exp_r.push_back(32'h1);
    bif.S_AXI_AWADDR = 4'h0; bif.S_AXI_AWVALID = 1'b1;
    bif.S_AXI_WDATA = 32'h55; bif.S_AXI_WSTRB = 4'hF; bif.S_AXI_WVALID = 1'b1;
    bif.S_AXI_ARADDR = 4'h0; bif.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0; bif.S_AXI_ARVALID = 1'b0;
    chk("collide_reg0", {96'd0, regs_out[31:0]}, {96'd0, 32'h55});
    drain();
    axi_read(4'h0, 32'h55);
    drain();

    // Reset mid-transaction: AW held, W not yet seen.
    bif.S_AXI_AWADDR = 4'h4; bif.S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bif.S_AXI_AWVALID = 1'b0;
    ARESET = 1'b1;
    #1;
    chk("mid_rst_ready", {125'd0, bif.S_AXI_AWREADY, bif.S_AXI_WREADY, bif.S_AXI_ARREADY}, 128'd0);
    chk("mid_rst_valid", {126'd0, bif.S_AXI_BVALID, bif.S_AXI_RVALID}, 128'd0);
    chk("mid_rst_regs", regs_out, 128'd0);
    @(posedge ACLK); #1; ARESET = 1'b0;
    @(posedge ACLK); #1;
    bif.S_AXI_WDATA = 32'hFFFFFFFF; bif.S_AXI_WSTRB = 4'hF; bif.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bif.S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("lone_w_no_b", {123'd0, bif.S_AXI_BVALID, reg_wr_pulse}, 128'd0);
    end
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) axi_read(4'(4*i), 32'h0);
    drain();
    chk("final_regs", regs_out, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_loop_regs.md
Name: axi_lite_loop_regs

Overview:
- AXI4-Lite slave register file: the responder end of the ctrl_AXIlite port that the master agent drives.
- Holds NUM_REGS 32-bit read/write control registers for the axi_stream_loop datapath and exposes them as a flat bus.
- Pulses a per-register update strobe whenever a register is written.

Parameters:
- DATA_WIDTH, 32, AXI data width. Only 32 is supported.
- ADDR_WIDTH, 4, AXI byte-address width.
- NUM_REGS, 4, number of word registers. Must equal 2**(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  sole clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  write protection. Ignored.
- S_AXI_AWVALID  in  1  write-address valid.
- S_AXI_AWREADY  out  1  write-address ready.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
- S_AXI_WVALID  in  1  write-data valid.
- S_AXI_WREADY  out  1  write-data ready.
- S_AXI_BRESP  out  2  write response. Always 2'b00 (OKAY).
- S_AXI_BVALID  out  1  write-response valid.
- S_AXI_BREADY  in  1  write-response ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  read protection. Ignored.
- S_AXI_ARVALID  in  1  read-address valid.
- S_AXI_ARREADY  out  1  read-address ready.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response. Always 2'b00.
- S_AXI_RVALID  out  1  read-data valid.
- S_AXI_RREADY  in  1  read-data ready.
- regs_out  out  NUM_REGS*DATA_WIDTH  register contents; reg k occupies bits [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe, bit k set on the cycle after reg k is written.

Behaviour:
- Single clock ACLK. Reset ARESET is asynchronous and active-high.
- Reset values:
  - All registers, RDATA and reg_wr_pulse are 0.
  - AWREADY, WREADY, BVALID and RVALID are 0.
  - AW and W holding latches are empty.
  - Ready outputs rise in the first cycle after ARESET deasserts.
- Address decode: word index = ADDR[ADDR_WIDTH-1:2]. ADDR[1:0] is ignored. Every address maps to a register, so there is no error response.
- Write path, AW and W channels are independent:
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - Each handshake captures its payload into its latch. AW and W may arrive in either order or in the same cycle.
  - Commit happens on the edge where both latches are full, or where the second handshake occurs. The commit:
    - writes each byte whose WSTRB bit is set and leaves the other bytes unchanged;
    - sets BVALID;
    - pulses reg_wr_pulse[idx] for one cycle;
    - clears both latches.
  - Latency: BVALID and the new register value are visible in the first cycle after the last of the AW/W handshakes.
  - BVALID holds until BREADY is seen. While BVALID is high, AWREADY and WREADY stay low, so at most one write is outstanding.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA is loaded with reg[idx] and RVALID goes high the next cycle.
  - RDATA and RVALID hold stable until RREADY. RVALID drops on the RREADY edge, and ARREADY returns the following cycle.
  - Throughput: one read per 2 cycles when RREADY is held high.
- Simultaneous write commit and AR handshake to the same index: RDATA returns the pre-write value. Reads and writes never stall each other.
- Master backpressure: holding BREADY or RREADY low stalls only that channel. There is no timeout.
- Reset mid-transaction: all VALID/READY outputs and latches clear immediately (asynchronously). A half-received AW or W is discarded with no register update. Register contents return to 0.
- Protocol: no output depends combinationally on any input VALID or READY.

Test Plan:
- Sequential write then readback: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read the same 4 addresses -> each BRESP=OKAY; reads return 0x1, 0x2, 0x3, 0x4; regs_out = 0x00000004_00000003_00000002_00000001.
- Byte strobes: reg1 = 0x11223344, then write 0xAABBCCDD to 0x4 with WSTRB=0x5 -> read 0x4 returns 0x11BB33DD; reg_wr_pulse = 4'b0010 for exactly one cycle.
- Channel ordering:
  - W presented 3 cycles before AW (addr 0x8, data 0xCAFE) -> WREADY handshakes alone, BVALID one cycle after the AW handshake, reg2 = 0xCAFE.
  - Repeat with AW first -> same result.
- Backpressure: BREADY held low 5 cycles after a write -> BVALID stays high, AWREADY and WREADY stay low, and a second AW/W is not accepted until BREADY.
  - Same check with RREADY low -> RDATA holds stable.
- Collision: write 0x55 to 0x0 commits in the same cycle as an AR to 0x0 (old value 0x1) -> RDATA = 0x1; a subsequent read returns 0x55.
- Reset mid-operation: AW accepted, W not yet presented, ARESET pulsed -> all outputs 0 within the same cycle; a later W alone produces no BVALID; all regs read back 0.
